// File: rtl/mem_arb.sv
// Two-port memory arbiter: serializes IF and LS accesses onto one memory port
// through IDLE/ISSUE/WAIT/RESP with a watchdog. Define MEM_ARB_RR_EN for round-robin.
module mem_arb #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic                ls_req_wen,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                rsp_err,
    output logic                mem_req_valid,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    localparam int MASK_W = DATA_W / 8;
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_reg, state_next;
    logic                owner_ls_reg;
    logic [7:0]          cnt_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                err_reg;
    logic                wen_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [MASK_W-1:0]   wmask_reg;
    logic                grant_ls, grant_if, accept, wait_done;

`ifdef MEM_ARB_RR_EN
    logic last_ls_reg;
`endif

    // Grants are only offered in IDLE and only to the single winner.
    always_comb begin
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (state_reg == IDLE) begin
`ifdef MEM_ARB_RR_EN
            if (ls_req_valid && if_req_valid) begin
                grant_ls = !last_ls_reg;
                grant_if = last_ls_reg;
            end else begin
                grant_ls = ls_req_valid;
                grant_if = if_req_valid;
            end
`else
            grant_ls = ls_req_valid;
            grant_if = if_req_valid && !ls_req_valid;
`endif
        end
    end

    assign accept    = grant_ls | grant_if;
    // Counter holds the number of WAIT cycles already spent, so the last allowed
    // WAIT cycle is the one where it equals TIMEOUT-1.
    assign wait_done = (cnt_reg == TMO - 8'd1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (mem_rsp_valid || wait_done) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            owner_ls_reg <= 1'b0;
            cnt_reg      <= 8'd0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            wen_reg      <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wmask_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                owner_ls_reg <= grant_ls;
                wen_reg      <= grant_ls & ls_req_wen;
                addr_reg     <= grant_ls ? ls_addr : if_addr;
                wdata_reg    <= grant_ls ? ls_wdata : '0;
                wmask_reg    <= grant_ls ? ls_wmask : '0;
            end
            if (state_reg == ISSUE) begin
                cnt_reg <= 8'd0;
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
            // A real response wins over a timeout landing in the same cycle.
            if (state_reg == WAIT) begin
                if (mem_rsp_valid) begin
                    rdata_reg <= wen_reg ? '0 : mem_rdata;
                    err_reg   <= 1'b0;
                end else if (wait_done) begin
                    rdata_reg <= '0;
                    err_reg   <= 1'b1;
                end
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ls_reg <= 1'b1;
        end else if (accept) begin
            last_ls_reg <= grant_ls;
        end
    end
`endif

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign if_rsp_valid  = (state_reg == RESP) && !owner_ls_reg;
    assign ls_rsp_valid  = (state_reg == RESP) && owner_ls_reg;
    assign if_rdata      = if_rsp_valid ? rdata_reg : '0;
    assign ls_rdata      = ls_rsp_valid ? rdata_reg : '0;
    assign rsp_err       = (state_reg == RESP) && err_reg;
    assign mem_req_valid = (state_reg == ISSUE);
    assign mem_wen       = wen_reg;
    assign mem_addr      = addr_reg;
    assign mem_wdata     = wdata_reg;
    assign mem_wmask     = wmask_reg;
    assign busy          = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed table, reset corner case and
// randomized transactions against a transaction-level reference model.
module tb_mem_arb;
    localparam int TMO = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_valid = 1'b0, ls_req_valid = 1'b0, ls_req_wen = 1'b0;
    logic        if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, rsp_err;
    logic [63:0] if_addr = '0, ls_addr = '0, ls_wdata = '0, mem_rdata = '0;
    logic [7:0]  ls_wmask = '0;
    logic [63:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_req_valid, mem_wen, busy;
    logic        mem_rsp_valid = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    bit model_last_ls;

    always #5 clk = ~clk;

    mem_arb #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_wen(ls_req_wen),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata), .rsp_err(rsp_err),
        .mem_req_valid(mem_req_valid), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        bit          ifv;
        bit          lsv;
        bit          wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          k;       // WAIT cycle (0-based) in which memory answers
        logic [63:0] mdata;
        bit          stray;   // pulse mem_rsp_valid during IDLE and ISSUE
        bit          exp_ls;
        logic [63:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " if_ready"}, if_req_ready, 0);
        chk({tag, " ls_ready"}, ls_req_ready, 0);
        chk({tag, " if_rsp"}, if_rsp_valid, 0);
        chk({tag, " ls_rsp"}, ls_rsp_valid, 0);
        chk({tag, " if_rdata"}, if_rdata, 0);
        chk({tag, " ls_rdata"}, ls_rdata, 0);
        chk({tag, " rsp_err"}, rsp_err, 0);
        chk({tag, " mem_req_valid"}, mem_req_valid, 0);
        chk({tag, " mem_wen"}, mem_wen, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " mem_wmask"}, mem_wmask, 0);
        chk({tag, " busy"}, busy, 0);
    endtask

    // Runs one access starting in an IDLE cycle and ends in the following IDLE cycle.
    task automatic run_txn(input string tag, input vec_t v);
        int wait_n, resp_at;
        if_req_valid  = v.ifv;
        ls_req_valid  = v.lsv;
        ls_req_wen    = v.wen;
        if_addr       = v.addr;
        ls_addr       = v.addr;
        ls_wdata      = v.wdata;
        ls_wmask      = v.wmask;
        mem_rsp_valid = v.stray;
        mem_rdata     = ~v.mdata;
        #1;
        chk({tag, " if_ready"}, if_req_ready, !v.exp_ls);
        chk({tag, " ls_ready"}, ls_req_ready, v.exp_ls);
        chk({tag, " idle busy"}, busy, 0);
        wait_n  = (v.k < TMO) ? v.k + 1 : TMO;
        resp_at = 2 + wait_n;
        for (int cyc = 1; cyc <= resp_at; cyc++) begin
            @(posedge clk);
            #1;
            mem_rsp_valid = (cyc == 1 && v.stray) || (cyc == 2 + v.k);
            mem_rdata     = (cyc == 2 + v.k) ? v.mdata : ~v.mdata;
            #1;
            chk({tag, " busy"}, busy, 1);
            chk({tag, " readies"}, {if_req_ready, ls_req_ready}, 0);
            chk({tag, " mem_req_valid"}, mem_req_valid, cyc == 1);
            chk({tag, " mem_addr"}, mem_addr, v.addr);
            if (cyc == 1) begin
                chk({tag, " mem_wen"}, mem_wen, v.exp_ls & v.wen);
                chk({tag, " mem_wmask"}, mem_wmask, v.exp_ls ? v.wmask : 8'h00);
                if (v.exp_ls) chk({tag, " mem_wdata"}, mem_wdata, v.wdata);
            end
            chk({tag, " if_rsp"}, if_rsp_valid, cyc == resp_at && !v.exp_ls);
            chk({tag, " ls_rsp"}, ls_rsp_valid, cyc == resp_at && v.exp_ls);
            if (cyc == resp_at) begin
                chk({tag, " rsp_err"}, rsp_err, v.exp_err);
                chk({tag, " rdata"}, v.exp_ls ? ls_rdata : if_rdata, v.exp_rdata);
            end
        end
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        $display("txn %s: owner=%s addr=%h k=%0d rdata=%h err=%0d", tag,
                 v.exp_ls ? "LS" : "IF", v.addr, v.k, v.exp_rdata, v.exp_err);
    endtask

    initial begin
        vec_t rv;
        // ifv lsv wen addr wdata wmask k mdata stray | exp_ls exp_rdata exp_err
        tbl[0] = '{1, 1, 0, 64'h100, 64'h0, 8'h00, 1, 64'h1111, 0, !RR, 64'h1111, 0};
        tbl[1] = '{1, 1, 0, 64'h108, 64'h0, 8'h00, 0, 64'h2222, 0, 1'b1, 64'h2222, 0};
        tbl[2] = '{1, 1, 0, 64'h110, 64'h0, 8'h00, 2, 64'h3333, 0, !RR, 64'h3333, 0};
        tbl[3] = '{1, 0, 0, 64'h8000_0000, 64'h0, 8'h00, 0, 64'hDEADBEEF, 0, 0, 64'hDEADBEEF, 0};
        tbl[4] = '{0, 1, 1, 64'h200, 64'h1122334455667788, 8'h0F, 0, 64'hCAFE, 0, 1, 64'h0, 0};
        tbl[5] = '{0, 1, 0, 64'h300, 64'h0, 8'h00, 10, 64'h55, 0, 1, 64'h0, 1};
        tbl[6] = '{0, 1, 0, 64'h308, 64'h0, 8'h00, 1, 64'h0123456789ABCDEF, 0, 1, 64'h0123456789ABCDEF, 0};
        tbl[7] = '{1, 0, 0, 64'h400, 64'h0, 8'h00, 0, 64'hA5A5A5A5A5A5A5A5, 1, 0, 64'hA5A5A5A5A5A5A5A5, 0};
        tbl[8] = '{0, 1, 0, 64'h408, 64'h0, 8'h00, 3, 64'h77, 1, 1, 64'h77, 0};
        tbl[9] = '{1, 0, 0, 64'h410, 64'h0, 8'h00, 4, 64'h99, 0, 0, 64'h0, 1};

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        model_last_ls = 1'b1;

        for (int i = 0; i < 10; i++) run_txn($sformatf("tbl%0d", i), tbl[i]);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;

        // Reset in the middle of WAIT, then a late memory response.
        @(posedge clk); #1;
        if_req_valid = 1'b1;
        if_addr = 64'h500;
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        @(posedge clk); #2;
        chk("midrst busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        model_last_ls = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata = 64'hBAD0BAD0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            #1;
            chk("late_rsp rsp_valid", {if_rsp_valid, ls_rsp_valid}, 0);
            chk("late_rsp busy", busy, 0);
            chk("late_rsp mem_req_valid", mem_req_valid, 0);
        end
        $display("txn midrst: access abandoned, late response ignored");

        // Randomized traffic against the transaction-level model.
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel      = $urandom_range(1, 3);
            rv.ifv   = sel[0];
            rv.lsv   = sel[1];
            rv.wen   = $urandom_range(0, 1);
            rv.addr  = {$urandom, $urandom};
            rv.wdata = {$urandom, $urandom};
            rv.wmask = 8'($urandom);
            rv.k     = $urandom_range(0, 6);
            rv.mdata = {$urandom, $urandom};
            rv.stray = $urandom_range(0, 1);
            if (rv.ifv && rv.lsv) rv.exp_ls = RR ? !model_last_ls : 1'b1;
            else                  rv.exp_ls = rv.lsv;
            model_last_ls = rv.exp_ls;
            rv.exp_err   = (rv.k >= TMO);
            rv.exp_rdata = (rv.exp_err || (rv.exp_ls && rv.wen)) ? 64'h0 : rv.mdata;
            run_txn($sformatf("rnd%0d", i), rv);
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        @(posedge clk); #1;
        chk("final busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
